// File: rtl/regfile_pkg.sv
// Shared types and constants for the dual-issue register file.
// Address/data typedefs, read-port count, hardwired zero register.
package regfile_pkg;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] word_t;

   localparam int        NUM_READ_PORTS = 4;
   localparam reg_addr_t ZERO_REG       = 5'd0;

   // True when an enabled write port targets the given address.
   function automatic logic wr_hit(
      input logic      en,
      input reg_addr_t dest,
      input reg_addr_t addr
   );
      return en && (dest == addr);
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port with same-cycle write forwarding.
// Ports: rst_i, addr_i, alpha/beta write enable/dest/data, stored_i in; data_o out.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  rst_i,
   input  reg_addr_t             addr_i,
   input  logic                  alpha_we_i,
   input  reg_addr_t             alpha_dest_i,
   input  logic [DATA_WIDTH-1:0] alpha_data_i,
   input  logic                  beta_we_i,
   input  reg_addr_t             beta_dest_i,
   input  logic [DATA_WIDTH-1:0] beta_data_i,
   input  logic [DATA_WIDTH-1:0] stored_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic hit_a;
   logic hit_b;

   assign hit_a = wr_hit(alpha_we_i, alpha_dest_i, addr_i);
   assign hit_b = wr_hit(beta_we_i, beta_dest_i, addr_i);

   // Beta is the younger instruction, so it outranks alpha,
   // matching the order in which storage resolves a collision.
   always_comb begin
      data_o = stored_i;
      if (rst_i || (addr_i == ZERO_REG)) begin
         data_o = '0;
      end else if (hit_b) begin
         data_o = beta_data_i;
      end else if (hit_a) begin
         data_o = alpha_data_i;
      end
   end

endmodule

// File: rtl/regfile_dual.sv
// Dual-write, quad-read register file with write-to-read forwarding.
// Ports: clk, rst, alpha/beta write en/dest/data in; rd_addr[4] in, rd_data[4] out.
module regfile_dual
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alpha_write_en,
   input  reg_addr_t             alpha_write_dest,
   input  logic [DATA_WIDTH-1:0] alpha_write_data,
   input  logic                  beta_write_en,
   input  reg_addr_t             beta_write_dest,
   input  logic [DATA_WIDTH-1:0] beta_write_data,
   input  reg_addr_t             rd_addr [NUM_READ_PORTS],
   output logic [DATA_WIDTH-1:0] rd_data [NUM_READ_PORTS]
);

   // Register 0 has no storage.
   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT-1:1];
   logic [DATA_WIDTH-1:0] regs_d [REG_COUNT-1:1];
   logic [DATA_WIDTH-1:0] stored [NUM_READ_PORTS];

   logic alpha_we;
   logic beta_we;

   assign alpha_we = alpha_write_en
                   && (alpha_write_dest != ZERO_REG)
                   && !rst;
   assign beta_we  = beta_write_en
                   && (beta_write_dest != ZERO_REG)
                   && !rst;

   // Beta is applied last so it wins a same-register collision.
   always_comb begin
      regs_d = regs_q;
      for (int r = 1; r < REG_COUNT; r++) begin
         if (wr_hit(alpha_we, alpha_write_dest, reg_addr_t'(r))) begin
            regs_d[r] = alpha_write_data;
         end
         if (wr_hit(beta_we, beta_write_dest, reg_addr_t'(r))) begin
            regs_d[r] = beta_write_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 1; r < REG_COUNT; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Array lookup per port; address 0 falls through to zero.
   always_comb begin
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
         stored[p] = '0;
         for (int r = 1; r < REG_COUNT; r++) begin
            if (rd_addr[p] == reg_addr_t'(r)) begin
               stored[p] = regs_q[r];
            end
         end
      end
   end

   for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
      regfile_read_port #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_port (
         .rst_i        (rst),
         .addr_i       (rd_addr[p]),
         .alpha_we_i   (alpha_we),
         .alpha_dest_i (alpha_write_dest),
         .alpha_data_i (alpha_write_data),
         .beta_we_i    (beta_we),
         .beta_dest_i  (beta_write_dest),
         .beta_data_i  (beta_write_data),
         .stored_i     (stored[p]),
         .data_o       (rd_data[p])
      );
   end

endmodule

// File: tb/tb_regfile_dual.sv
// Scoreboard bench for regfile_dual: directed plan then random traffic.
// Driver pushes expected reads; monitor pops and compares each cycle.
module tb_regfile_dual;
   import regfile_pkg::*;

   logic      clk;
   logic      rst;
   logic      alpha_write_en;
   reg_addr_t alpha_write_dest;
   word_t     alpha_write_data;
   logic      beta_write_en;
   reg_addr_t beta_write_dest;
   word_t     beta_write_data;
   reg_addr_t rd_addr [NUM_READ_PORTS];
   word_t     rd_data [NUM_READ_PORTS];

   regfile_dual #(
      .DATA_WIDTH (32),
      .REG_COUNT  (32)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .alpha_write_en   (alpha_write_en),
      .alpha_write_dest (alpha_write_dest),
      .alpha_write_data (alpha_write_data),
      .beta_write_en    (beta_write_en),
      .beta_write_dest  (beta_write_dest),
      .beta_write_data  (beta_write_data),
      .rd_addr          (rd_addr),
      .rd_data          (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int    id;
      word_t d [NUM_READ_PORTS];
   } exp_t;

   exp_t  sb [$];
   word_t mem [32];
   int    total = 0;
   int    bad = 0;
   int    ncyc = 0;

   // Architectural view: the register file after this cycle's
   // edge, where reads this cycle equal that next-state value.
   task automatic cyc(
      input logic      r,
      input logic      ae, input reg_addr_t ad, input word_t adt,
      input logic      be, input reg_addr_t bd, input word_t bdt,
      input reg_addr_t a0, input reg_addr_t a1,
      input reg_addr_t a2, input reg_addr_t a3
   );
      word_t nxt [32];
      exp_t  e;
      @(posedge clk);
      #1;
      rst = r;
      alpha_write_en = ae; alpha_write_dest = ad; alpha_write_data = adt;
      beta_write_en = be; beta_write_dest = bd; beta_write_data = bdt;
      rd_addr[0] = a0; rd_addr[1] = a1;
      rd_addr[2] = a2; rd_addr[3] = a3;
      nxt = mem;
      if (r) begin
         foreach (nxt[i]) nxt[i] = '0;
      end else begin
         if (ae) nxt[ad] = adt;
         if (be) nxt[bd] = bdt;
         nxt[0] = '0;
      end
      e.id = ncyc;
      e.d[0] = nxt[a0]; e.d[1] = nxt[a1];
      e.d[2] = nxt[a2]; e.d[3] = nxt[a3];
      sb.push_back(e);
      mem = nxt;
      ncyc++;
   endtask

   // Monitor: read ports are always valid, so one entry per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
               total++;
               if (rd_data[p] !== e.d[p]) begin
                  bad++;
                  $display("FAIL rd%0d cyc%0d addr=%0d got=%h exp=%h",
                           p, e.id, rd_addr[p], rd_data[p], e.d[p]);
               end
            end
         end
      end
   end

   function automatic reg_addr_t rnd_addr();
      if ($urandom_range(1, 0) == 1) return reg_addr_t'($urandom_range(7, 0));
      return reg_addr_t'($urandom_range(31, 0));
   endfunction

   initial begin
      foreach (mem[i]) mem[i] = '0;
      rst = 1'b1;
      alpha_write_en = 1'b0; alpha_write_dest = '0; alpha_write_data = '0;
      beta_write_en = 1'b0; beta_write_dest = '0; beta_write_data = '0;
      foreach (rd_addr[i]) rd_addr[i] = '0;

      // reset state
      cyc(1, 0, 0, 0, 0, 0, 0, 5, 1, 31, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 5, 1, 31, 9);
      // preload r5, then reset with beta writing r9
      cyc(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 5, 5, 5, 5);
      cyc(1, 0, 0, 0, 1, 9, 32'hFFFF_FFFF, 5, 5, 9, 9);
      cyc(0, 0, 0, 0, 0, 0, 0, 5, 9, 5, 9);
      // zero register
      cyc(0, 1, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // forwarding on a beta-slot port
      cyc(0, 1, 3, 32'hA5A5_0001, 0, 0, 0, 0, 0, 3, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      // collision, beta wins
      cyc(0, 1, 7, 32'h1, 1, 7, 32'h2, 7, 7, 7, 7);
      cyc(0, 0, 0, 0, 0, 0, 0, 7, 0, 7, 0);
      // independent dual write
      cyc(0, 1, 1, 32'h11, 1, 31, 32'h22, 1, 31, 1, 31);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 31, 1, 31);
      // collision with beta writing to r0: alpha must land
      cyc(0, 1, 4, 32'h44, 1, 0, 32'h99, 4, 0, 4, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 4, 0, 4, 0);

      for (int k = 0; k < 600; k++) begin
         cyc(($urandom_range(31, 0) == 0),
             1'($urandom), rnd_addr(), $urandom,
             1'($urandom), rnd_addr(), $urandom,
             rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr());
      end

      for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clk);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain left=%0d exp=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
